// File: rtl/pwm_button_conditioner.sv
// Push-button conditioner feeding the PWM duty-cycle generator.
// Each button (index 0 = increase, 1 = decrease) is synchronised, debounced
// on a slow sample tick, edge-detected and optionally auto-repeated while
// held. The two step pulses are single-cycle and never asserted together.
module pwm_button_conditioner #(
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_inc,
    input  logic btn_dec,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_level,
    output logic dec_level
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int SW   = $clog2(STABLE_TICKS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam bit RPT_EN = (REPEAT_DELAY > 0);

    localparam logic [PW-1:0] PS_LAST   = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] ST_LAST   = SW'(STABLE_TICKS - 1);
    // The repeat counter holds "ticks seen minus one", so a match on the
    // *_LAST value means the current tick is the scheduled one.
    localparam logic [RW-1:0] DLY_LAST  = RW'(RPT_EN ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [1:0]    flip;
    logic [1:0]    rpt_evt;
    logic [1:0]    rpt_on;
    logic [1:0]    fire;
    logic [1:0]    pulse_q;
    logic [PW-1:0] ps_cnt;
    logic [SW-1:0] stab_cnt [2];
    logic [RW-1:0] rpt_cnt  [2];
    logic          tick;
    logic          lock;

    assign btn_raw = {btn_dec, btn_inc};
    assign tick    = ena && (ps_cnt == PS_LAST);
    // Both buttons accepted as pressed: the request is ambiguous, so lock out.
    assign lock    = deb[0] & deb[1];

    // Two-flop synchronisers; they keep sampling even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce sample prescaler, frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (ena) begin
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PW'(1);
        end
    end

    // A tick on which the differing level completes its stability run.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 2; i++) begin
            flip[i] = tick && (sync2[i] != deb[i]) && (stab_cnt[i] == ST_LAST);
        end
    end

    // Debounce filter: a new level must differ on consecutive ticks to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < 2; i++) stab_cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    stab_cnt[i] <= '0;
                end else if (flip[i]) begin
                    deb[i]      <= ~deb[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + SW'(1);
                end
            end
        end
    end

    // Hold-to-repeat scheduler: first event after the delay, then at the rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_evt <= '0;
            rpt_on  <= '0;
            for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
        end else if (ena) begin
            for (int i = 0; i < 2; i++) begin
                rpt_evt[i] <= 1'b0;
                // Released, locked out, or changing level this tick: restart
                // the schedule so the next hold begins with the full delay.
                if (!deb[i] || lock || flip[i]) begin
                    rpt_cnt[i] <= '0;
                    rpt_on[i]  <= 1'b0;
                end else if (tick) begin
                    if (rpt_cnt[i] == (rpt_on[i] ? RATE_LAST : DLY_LAST)) begin
                        rpt_cnt[i] <= '0;
                        rpt_on[i]  <= 1'b1;
                        rpt_evt[i] <= RPT_EN;
                    end else begin
                        rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
                    end
                end
            end
        end
    end

    // Press edges and repeat events merged; any conflict suppresses both.
    always_comb begin
        fire = (deb & ~deb_d) | rpt_evt;
        if (!ena || lock || (&fire)) fire = '0;
    end

    // Output pulse register and the edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_d   <= '0;
            pulse_q <= '0;
        end else begin
            pulse_q <= fire;
            if (ena) deb_d <= deb;
        end
    end

    assign inc_pulse = pulse_q[0];
    assign dec_pulse = pulse_q[1];
    assign inc_level = deb[0];
    assign dec_level = deb[1];

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// Bench for pwm_button_conditioner: two instances share the stimulus, one
// with auto-repeat disabled and one with a short repeat schedule.
module tb_pwm_button_conditioner;

    localparam int TD  = 4;
    localparam int ST  = 3;
    localparam int RR  = 4;
    localparam int RD1 = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [1:0] inc_pulse, dec_pulse, inc_level, dec_level;

    always #5 clk = ~clk;

    pwm_button_conditioner #(.TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(0), .REPEAT_RATE(RR)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .inc_pulse(inc_pulse[0]), .dec_pulse(dec_pulse[0]),
        .inc_level(inc_level[0]), .dec_level(dec_level[0]));

    pwm_button_conditioner #(.TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD1), .REPEAT_RATE(RR)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .inc_pulse(inc_pulse[1]), .dec_pulse(dec_pulse[1]),
        .inc_level(inc_level[1]), .dec_level(dec_level[1]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cfg_delay [2] = '{0, RD1};

    // Reference model state, per instance [c] and per button [i].
    bit m_s1 [2][2], m_s2 [2][2], m_lvl [2][2], m_lvl_d [2][2], m_evt [2][2], m_pulse [2][2];
    int m_run [2][2], m_anchor [2][2];
    int m_total [2];
    int m_en [2];

    // Observed pulse statistics since the last reset.
    int pcount [2][2], pfirst [2][2];
    bit pbefore [2][2], prev_lvl [2][2];
    int inc_t1 [$];

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_total[c] = 0;
            m_en[c] = 0;
            for (int i = 0; i < 2; i++) begin
                m_s1[c][i] = 0; m_s2[c][i] = 0; m_lvl[c][i] = 0; m_lvl_d[c][i] = 0;
                m_evt[c][i] = 0; m_pulse[c][i] = 0; m_run[c][i] = 0; m_anchor[c][i] = 0;
            end
        end
    endtask

    // Advance the model across one rising edge using the present inputs.
    // Ticks: every TD-th enabled cycle. Debounce: run length of differing
    // ticks. Repeat: ticks elapsed since the hold started, compared with the
    // delay/rate schedule arithmetically.
    task automatic model_edge();
        bit b [2];
        bit f [2];
        bit fl [2];
        bit pn [2];
        bit tick, lock;
        int n;
        b[0] = btn_inc;
        b[1] = btn_dec;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            tick = ena && ((m_en[c] % TD) == TD - 1);
            lock = m_lvl[c][0] && m_lvl[c][1];
            for (int i = 0; i < 2; i++) f[i] = (m_lvl[c][i] && !m_lvl_d[c][i]) || m_evt[c][i];
            for (int i = 0; i < 2; i++) pn[i] = ena && !lock && !(f[0] && f[1]) && f[i];
            for (int i = 0; i < 2; i++) begin
                fl[i] = 0;
                if (tick) begin
                    if (m_s2[c][i] != m_lvl[c][i]) begin
                        m_run[c][i]++;
                        if (m_run[c][i] == ST) begin
                            fl[i] = 1;
                            m_run[c][i] = 0;
                        end
                    end else begin
                        m_run[c][i] = 0;
                    end
                end
            end
            if (tick) m_total[c]++;
            for (int i = 0; i < 2; i++) begin
                if (ena) begin
                    m_evt[c][i] = 0;
                    if (!m_lvl[c][i] || lock || fl[i]) begin
                        m_anchor[c][i] = m_total[c];
                    end else if (tick && cfg_delay[c] > 0) begin
                        n = m_total[c] - m_anchor[c][i];
                        if (n == cfg_delay[c] || (n > cfg_delay[c] && ((n - cfg_delay[c]) % RR) == 0))
                            m_evt[c][i] = 1;
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (ena) m_lvl_d[c][i] = m_lvl[c][i];
                m_lvl[c][i] = m_lvl[c][i] ^ fl[i];
                m_s2[c][i] = m_s1[c][i];
                m_s1[c][i] = b[i];
                m_pulse[c][i] = pn[i];
            end
            if (ena) m_en[c]++;
        end
    endtask

    task automatic compare_model();
        logic [3:0] act, exp;
        for (int c = 0; c < 2; c++) begin
            act = {inc_pulse[c], dec_pulse[c], inc_level[c], dec_level[c]};
            exp = {m_pulse[c][0], m_pulse[c][1], m_lvl[c][0], m_lvl[c][1]};
            checks++;
            if (act !== exp) begin
                failures++;
                if (failures < 40)
                    $display("FAIL model_dut%0d cyc=%0d: actual {ip,dp,il,dl}=%b required=%b", c, cyc, act, exp);
            end
            checks++;
            if (inc_pulse[c] && dec_pulse[c]) begin
                failures++;
                if (failures < 40) $display("FAIL excl_dut%0d cyc=%0d: actual both=1 required=0", c, cyc);
            end
        end
    endtask

    // One clock: model edge, DUT edge, sample on the falling edge.
    task automatic cycle();
        bit lv, pl;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_model();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                lv = (i == 0) ? inc_level[c] : dec_level[c];
                pl = (i == 0) ? inc_pulse[c] : dec_pulse[c];
                if (pl) begin
                    pcount[c][i]++;
                    if (pfirst[c][i] < 0) begin
                        pfirst[c][i] = cyc;
                        pbefore[c][i] = prev_lvl[c][i];
                    end
                end
                prev_lvl[c][i] = lv;
            end
        end
        if (inc_pulse[1]) inc_t1.push_back(cyc);
        cyc++;
    endtask

    // Asynchronous reset assertion (checked before any clock edge), then release.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_int("reset_async_outputs", int'({inc_pulse, dec_pulse, inc_level, dec_level}), 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cyc = 0;
        inc_t1.delete();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                pcount[c][i] = 0; pfirst[c][i] = -1; pbefore[c][i] = 0; prev_lvl[c][i] = 0;
            end
        end
    endtask

    typedef struct {
        int dut;
        bit dec;
        int hold;
        int exp_n;
        int lo;
        int hi;
        bit exp_lvl;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        vec_t v;
        int   b, fall, frozen;
        int   exp3 [6];
        int   exp5 [4];

        vecs[0] = '{0, 1'b0, 40, 1, 12, 15, 1'b1};
        vecs[1] = '{0, 1'b1,  5, 0,  0,  0, 1'b0};
        vecs[2] = '{0, 1'b1,  8, 0,  0,  0, 1'b0};
        vecs[3] = '{1, 1'b1, 25, 1, 12, 15, 1'b1};
        vecs[4] = '{0, 1'b1, 40, 1, 12, 15, 1'b1};
        exp3 = '{12, 44, 60, 76, 92, 108};
        exp5 = '{12, 44, 100, 116};

        #2;
        do_reset();
        ena = 1'b1;

        // Table: single presses and rejected glitches.
        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            b = v.dec ? 1 : 0;
            do_reset();
            ena = 1'b1;
            for (int t = 0; t < v.hold; t++) begin
                btn_inc = !v.dec;
                btn_dec = v.dec;
                cycle();
            end
            check_int($sformatf("vec%0d_level_end_of_hold", k),
                      v.dec ? int'(dec_level[v.dut]) : int'(inc_level[v.dut]), int'(v.exp_lvl));
            btn_inc = 1'b0;
            btn_dec = 1'b0;
            repeat (40) cycle();
            check_int($sformatf("vec%0d_pulse_count", k), pcount[v.dut][b], v.exp_n);
            check_int($sformatf("vec%0d_other_pulses", k), pcount[v.dut][1-b], 0);
            if (v.exp_n > 0) begin
                check_int($sformatf("vec%0d_first_in_window", k),
                          int'(pfirst[v.dut][b] >= v.lo && pfirst[v.dut][b] <= v.hi), 1);
                check_int($sformatf("vec%0d_level_before_pulse", k), int'(pbefore[v.dut][b]), 1);
            end
        end

        // Hold-to-repeat schedule, then release.
        do_reset();
        ena = 1'b1;
        btn_inc = 1'b1;
        repeat (113) cycle();
        btn_inc = 1'b0;
        repeat (60) cycle();
        check_int("rpt_pulse_count", inc_t1.size(), 6);
        for (int j = 0; j < 6; j++)
            if (j < inc_t1.size()) check_int($sformatf("rpt_pulse_%0d", j), inc_t1[j], exp3[j]);
        check_int("rpt_no_dec", pcount[1][1], 0);

        // Both held: lockout; releasing dec restarts the inc schedule.
        do_reset();
        ena = 1'b1;
        btn_inc = 1'b1;
        repeat (20) cycle();
        btn_dec = 1'b1;
        repeat (60) cycle();
        check_int("lock_inc_pulses", inc_t1.size(), 1);
        check_int("lock_dec_pulses", pcount[1][1], 0);
        check_int("lock_both_levels", int'(inc_level[1] && dec_level[1]), 1);
        btn_dec = 1'b0;
        fall = -1;
        for (int t = 0; t < 100; t++) begin
            cycle();
            if (fall < 0 && !dec_level[1]) fall = cyc - 1;
        end
        check_int("lock_release_seen", int'(fall >= 0), 1);
        check_int("lock_resume_present", int'(inc_t1.size() >= 2), 1);
        // Event on the RD1-th tick after the release tick, plus one pulse-register cycle.
        if (inc_t1.size() >= 2) check_int("lock_resume_cycle", inc_t1[1] - fall, TD * RD1 + 1);
        check_int("lock_no_dec_on_release", pcount[1][1], 0);
        btn_inc = 1'b0;

        // Enable low freezes the schedule mid-hold.
        do_reset();
        ena = 1'b1;
        btn_inc = 1'b1;
        repeat (51) cycle();
        ena = 1'b0;
        frozen = inc_t1.size();
        repeat (40) cycle();
        check_int("ena_no_pulses", inc_t1.size() - frozen, 0);
        check_int("ena_level_held", int'(inc_level[1]), 1);
        ena = 1'b1;
        repeat (40) cycle();
        check_int("ena_pulse_count", inc_t1.size(), 4);
        for (int j = 0; j < 4; j++)
            if (j < inc_t1.size()) check_int($sformatf("ena_pulse_%0d", j), inc_t1[j], exp5[j]);

        // Reset mid-repeat with the button still held.
        check_int("midrst_level_before", int'(inc_level[1]), 1);
        do_reset();
        repeat (30) cycle();
        check_int("midrst_new_press_count", pcount[1][0], 1);
        check_int("midrst_new_press_window", int'(pfirst[1][0] >= 12 && pfirst[1][0] <= 15), 1);
        check_int("midrst_dut0_press", pcount[0][0], 1);
        btn_inc = 1'b0;

        // Randomised segments checked cycle by cycle against the model.
        do_reset();
        ena = 1'b1;
        for (int seg = 0; seg < 160; seg++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 20);
            btn_inc = $urandom_range(0, 1);
            btn_dec = ($urandom_range(0, 2) == 0);
            ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) do_reset();
            repeat (len) cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
